// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - state, opcode and ALUOp definitions shared by the control FSM and ALU control decoder
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SLTI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;

  localparam logic [2:0] ALUOP_R   = 3'b000;
  localparam logic [2:0] ALUOP_AND = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b100;
  localparam logic [2:0] ALUOP_OR  = 3'b101;
  localparam logic [2:0] ALUOP_SLT = 3'b110;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Opcodes above J are unassigned and trap as illegal.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_J);
  endfunction

endpackage

// File: rtl/main_control_next.sv
// rtl/main_control_next.sv - combinational next-state logic of the multicycle control FSM
module main_control_next
  import main_control_fsm_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_mem_ready,
  output state_t     o_next
);

  always_comb begin
    o_next = S_FETCH;
    case (i_state)
      S_START:    o_next = S_FETCH;
      S_FETCH:    o_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_R:                              o_next = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: o_next = S_EXEC_I;
          OP_LW, OP_SW:                      o_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    o_next = S_BRANCH;
          OP_J:                              o_next = S_JUMP;
          default:                           o_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: o_next = (i_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   o_next = i_mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   o_next = i_mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R,
      S_EXEC_I:   o_next = S_ALU_WB;
      default:    o_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle CPU main control: state register and per-state output decode
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] ALUOp,
  output logic       illegal_op
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_opcode;

  main_control_next u_next (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .o_next      (w_next)
  );

  // Opcode is latched in DECODE so later instruction-register changes cannot disturb execute states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_START;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode;
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_source  = PCSRC_ALU;
    ALUOp      = ALUOP_R;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ALUOp     = ALUOP_ADD;
        pc_source = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_SEXT;
        ALUOp      = ALUOP_ADD;
        illegal_op = !is_legal_op(opcode);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        ALUOp     = ALUOP_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALUOp     = ALUOP_R;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        case (r_opcode)
          OP_ANDI: begin ALUOp = ALUOP_AND; alu_src_b = SRCB_ZEXT; end
          OP_ORI:  begin ALUOp = ALUOP_OR;  alu_src_b = SRCB_ZEXT; end
          OP_SLTI: begin ALUOp = ALUOP_SLT; alu_src_b = SRCB_SEXT; end
          default: begin ALUOp = ALUOP_ADD; alu_src_b = SRCB_SEXT; end
        endcase
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (r_opcode == OP_R);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUOp     = ALUOP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = (r_opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  single system clock, rising-edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: opcode  in  4  instruction opcode from the instruction register.
REQ-004 SHALL have: mem_ready  in  1  memory completes the current access this cycle.
REQ-005 SHALL have: zero  in  1  ALU zero flag, used for branches.
REQ-006 SHALL have outputs (1 bit): mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a.
REQ-007 SHALL have outputs: alu_src_b  out  2  (00 regB, 01 const 1, 10 sign-ext imm, 11 zero-ext imm); pc_source  out  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-008 SHALL have: ALUOp  out  3  operation class consumed by the ALU control decoder; illegal_op  out  1  one-cycle pulse.

Function
REQ-009 SHALL implement a multicycle FSM with states START, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
REQ-010 SHALL drive all outputs as decodes of the current state, except ir_write, pc_write and pc_write gating, which are additionally qualified by the current cycle's mem_ready or zero as stated below.
REQ-011 START: all outputs 0; next state FETCH unconditionally.
REQ-012 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOp=010, pc_source=00; ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
REQ-013 DECODE: alu_src_a=0, alu_src_b=10, ALUOp=010 (branch target precompute); next state chosen by opcode.
REQ-014 Opcode map: 0000 R -> EXEC_R; 0001 ADDI, 0010 ANDI, 0011 ORI, 0100 SLTI -> EXEC_I; 0101 LW, 0110 SW -> MEM_ADDR; 0111 BEQ, 1000 BNE -> BRANCH; 1001 J -> JUMP.
REQ-015 Opcodes 1010-1111 SHALL pulse illegal_op for the DECODE cycle and return to FETCH with no register or memory write.
REQ-016 EXEC_R: alu_src_a=1, alu_src_b=00, ALUOp=000; next ALU_WB with reg_dst=1.
REQ-017 EXEC_I: alu_src_a=1; ALUOp ADDI 010, ANDI 001, ORI 101, SLTI 110; alu_src_b=10 for ADDI/SLTI, 11 for ANDI/ORI; next ALU_WB with reg_dst=0.
REQ-018 ALU_WB: reg_write=1, mem_to_reg=0; reg_dst held from the preceding execute state; next FETCH.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=010; next MEM_RD for LW, MEM_WR for SW.
REQ-020 MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-021 MEM_WR: mem_write=1, i_or_d=1; held until mem_ready=1, then FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=100, pc_source=01; pc_write=zero for BEQ, ~zero for BNE; next FETCH.
REQ-023 JUMP: pc_source=10, pc_write=1; next FETCH.
REQ-024 mem_read and mem_write SHALL never be asserted in the same cycle; reg_write and pc_write SHALL each be asserted for exactly one cycle per instruction that requires them.
REQ-025 The opcode SHALL be sampled only in DECODE and MEM_ADDR; later changes have no effect.

Reset
REQ-026 rst_n low SHALL force state START immediately, asynchronously, regardless of the clock.
REQ-027 Reset mid-access (e.g. in MEM_WR) SHALL deassert mem_write immediately; no write completes afterwards.
REQ-028 After rst_n rises, START SHALL last exactly one clock, then FETCH.

Structure
REQ-029 A shared package SHALL hold the state enumeration, opcode constants and ALUOp constants (000 R, 001, 010 add, 011, 100 sub, 101, 110), which the ALU control decoder uses as well.
REQ-030 A single sub-module, main_control_next, SHALL hold the combinational next-state logic; output decode and the state register remain in main_control_fsm.

Verification
REQ-031 Reset then opcode=0000, mem_ready=1 -> states START, FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 5, with ALUOp=000 in EXEC_R.
REQ-032 LW (0101) with mem_ready low for 3 cycles in MEM_RD -> mem_read=1 and i_or_d=1 held for 4 cycles; reg_write=1, mem_to_reg=1 exactly once.
REQ-033 BEQ with zero=1 -> pc_write=1 in BRANCH; BNE with zero=1 -> pc_write=0; ALUOp=100 in both.
REQ-034 Opcode=1100 -> illegal_op pulses once in DECODE, next state FETCH, no reg_write or mem_write.
REQ-035 rst_n dropped between clock edges during MEM_WR -> mem_write falls without a clock edge; after release, one START cycle then FETCH.
REQ-036 ORI (0011) -> EXEC_I with ALUOp=101 and alu_src_b=11, followed by ALU_WB with reg_dst=0.
